// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core:
// opcodes, function codes, FSM states and ALU operations.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_LUI
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    function automatic logic is_legal(input logic [5:0] op,
                                      input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_JR, FN_ADDU, FN_SUBU,
                    FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:               ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU,
            OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_e alu_sel(input logic [5:0] op,
                                        input logic [5:0] fn);
        alu_op_e sel;
        sel = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUBU: sel = ALU_SUB;
                    FN_AND:  sel = ALU_AND;
                    FN_OR:   sel = ALU_OR;
                    FN_SLT:  sel = ALU_SLT;
                    FN_SLL:  sel = ALU_SLL;
                    default: sel = ALU_ADD;
                endcase
            end
            OP_ORI:  sel = ALU_OR;
            OP_LUI:  sel = ALU_LUI;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two asynchronous read ports and one write port.
// r0 is hardwired to zero on read and never written.
module reg_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra_a_i,
    input  logic [4:0]  ra_b_i,
    output logic [31:0] rd_a_o,
    output logic [31:0] rd_b_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ra_a_i == 5'd0) ? 32'd0 : regs_q[ra_a_i];
    assign rd_b_o = (ra_b_i == 5'd0) ? 32'd0 : regs_q[ra_b_i];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT
// sequencer around a single shared memory bus.
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [31:0]      data_result,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    state_e           state_q, state_d;
    logic             live_q;
    logic [31:0]      pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic [CNT_W-1:0] ret_q;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic        is_r, is_ld, is_st, is_jr, is_jmp, is_ctl, take;
    logic        fetch_ack, data_ack, retire;
    logic [31:0] rs_val, rt_val, imm_ext, opnd, alu_res;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op     = ir_q[31:26];
    assign fn     = ir_q[5:0];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign is_r   = (op == OP_RTYPE);
    assign is_ld  = (op == OP_LW);
    assign is_st  = (op == OP_SW);
    assign is_jr  = is_r && (fn == FN_JR);
    assign is_jmp = (op == OP_J) || (op == OP_JAL);
    assign take   = ((op == OP_BEQ) && (a_q == b_q))
                 || ((op == OP_BNE) && (a_q != b_q));
    assign is_ctl = (op == OP_BEQ) || (op == OP_BNE)
                 || is_jmp || is_jr;

    assign imm_ext = (op == OP_ORI) ? {16'h0, ir_q[15:0]}
                                    : {{16{ir_q[15]}}, ir_q[15:0]};

    // live_q keeps the bus idle until the first edge after reset release
    assign mem_req   = live_q && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = live_q && (state_q == S_MEM) && is_st;
    assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata = b_q;
    assign fetch_ack = mem_req && mem_ack && (state_q == S_FETCH);
    assign data_ack  = mem_req && mem_ack && (state_q == S_MEM);

    assign retire = ((state_q == S_EXEC) && is_ctl)
                 || (data_ack && is_st)
                 || (state_q == S_WB);

    assign data_result = alu_q;
    assign retired     = ret_q;
    assign halted      = (state_q == S_HALT);

    assign rf_we = (state_q == S_WB)
                || ((state_q == S_EXEC) && (op == OP_JAL));
    assign rf_wa = (state_q == S_EXEC) ? 5'd31 : (is_r ? rd : rt);
    assign rf_wd = (state_q == S_EXEC) ? pc_q : (is_ld ? mdr_q : alu_q);

    reg_file u_rf (
        .clk_i  (clock),
        .rst_ni (reset),
        .ra_a_i (rs),
        .ra_b_i (rt),
        .rd_a_o (rs_val),
        .rd_b_o (rt_val),
        .we_i   (rf_we),
        .wa_i   (rf_wa),
        .wd_i   (rf_wd)
    );

    always_comb begin
        opnd    = is_r ? b_q : imm_q;
        alu_res = '0;
        case (alu_sel(op, fn))
            ALU_ADD: alu_res = a_q + opnd;
            ALU_SUB: alu_res = a_q - opnd;
            ALU_AND: alu_res = a_q & opnd;
            ALU_OR:  alu_res = a_q | opnd;
            ALU_SLT: alu_res = {31'd0, $signed(a_q) < $signed(opnd)};
            ALU_SLL: alu_res = b_q << shamt;
            ALU_LUI: alu_res = {imm_q[15:0], 16'h0};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_ack) state_d = S_DECODE;
            S_DECODE: state_d = is_legal(op, fn) ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_ld || is_st) state_d = S_MEM;
                else if (is_ctl)    state_d = S_FETCH;
                else                state_d = S_WB;
            end
            S_MEM:    if (data_ack) state_d = is_ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            live_q  <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (fetch_ack) begin
                ir_q <= mem_rdata;
                pc_q <= pc_q + 32'd4;
            end
            if (state_q == S_DECODE) begin
                a_q   <= rs_val;
                b_q   <= rt_val;
                imm_q <= imm_ext;
            end
            if (state_q == S_EXEC) begin
                if (take)        pc_q <= pc_q + {imm_q[29:0], 2'b00};
                else if (is_jmp) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                else if (is_jr)  pc_q <= a_q;
                if (!is_ctl)     alu_q <= alu_res;
            end
            if (data_ack && is_ld) mdr_q <= mem_rdata;
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports mem_req, output, 1 and mem_we, output, 1: bus request and write enable.
REQ-006 SHALL have ports mem_addr, output, 32 and mem_wdata, output, 32: word address and store data.
REQ-007 SHALL have ports mem_rdata, input, 32 and mem_ack, input, 1: read data and completion, valid on the same cycle.
REQ-008 SHALL have port data_result, output, 32: last ALU result.
REQ-009 SHALL have port retired, output, CNT_W: instructions completed.
REQ-010 SHALL have port halted, output, 1: high after an illegal opcode.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH/MEM, which hold until mem_ack.
REQ-012 SHALL support addu, subu, and, or, slt, sll, jr, addiu, ori, lui, lw, sw, beq, bne, j, jal; all other encodings SHALL enter HALT from DECODE.
REQ-013 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack latch IR, PC<=PC+4, go to DECODE; an ack in the first FETCH cycle is legal (minimum 1 cycle).
REQ-014 DECODE: read rs/rt from the register file and sign- or zero-extend imm (zero for ori, sign otherwise).
REQ-015 EXEC: ALU result to data_result; R-type/immediate go to WB; lw/sw go to MEM (addr = rs + sext(imm)).
REQ-016 Branch: target = (PC+4) + (sext(imm)<<2); the decision is made in EXEC, and control returns to FETCH; taken and not-taken both retire.
REQ-017 j/jal: PC <= {PC[31:28], instr_index, 2'b00}; jal SHALL write PC+4 to r31; jr: PC <= rs.
REQ-018 MEM: mem_req=1, mem_we=1 for sw with mem_wdata=rt; lw latches mem_rdata on ack and goes to WB; sw goes to FETCH on ack.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant while mem_req=1 and mem_ack=0.
REQ-020 WB: write rd (R-type) or rt (I-type/lw); writes to r0 SHALL be discarded; r0 SHALL read 0.
REQ-021 Arithmetic SHALL be modulo 2^32 with no overflow traps; slt SHALL be signed.
REQ-022 retired SHALL increment by 1 on every instruction completion (WB exit, store ack, branch/jump EXEC exit) and wrap to 0 after all-ones.
REQ-023 HALT: mem_req=0 and halted=1 until reset; retired SHALL not count the illegal instruction.
REQ-024 mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-025 On reset low, asynchronously: state=FETCH, PC=RESET_PC, IR=0, data_result=0, retired=0, halted=0, mem_req=0, mem_we=0; all registers = 0.
REQ-026 mem_req SHALL assert no earlier than the first clock edge after reset deasserts.
REQ-027 Reset mid-access SHALL abandon the bus transaction; a late mem_ack SHALL be ignored.

Structure
REQ-028 Opcode/funct constants, the state enum and ALU op codes SHALL live in a shared package, cpu_pkg.
REQ-029 The 32x32 register file (2 read ports, 1 write port) SHALL be a sub-module, reg_file.

Verification
REQ-030 Zero-wait memory, addiu r1,r0,5; addiu r2,r0,-3; addu r3,r1,r2 -> r3=2, data_result=2, retired=3 after 12 cycles.
REQ-031 lw r4,8(r0) with 3 wait states, mem[8]=32'hDEADBEEF -> r4=32'hDEADBEEF, request signals stable for all 4 cycles.
REQ-032 beq r0,r0,-1 at PC 0x10 -> next fetch at 0x10; bne r0,r0,4 -> next fetch at 0x14.
REQ-033 jal 0x40 at PC 0x20 -> r31=0x24, next fetch 0x100; jr r31 -> fetch 0x24.
REQ-034 Opcode 6'h3F -> halted=1, mem_req=0, retired unchanged; reset low releases to fetch at RESET_PC.
REQ-035 CNT_W=4, 17 addiu instructions -> retired wraps to 1; reset asserted during a pending sw -> no write retried, retired=0.
